l2_buf_read_server: RTL and testbench
=====================================

# l2_buf_read_server

Synthesizable L2 weight/activation buffer that answers the DLA core's `*_buf_read_ready` / `*_buf_read_addr` requests with `*_buf_read_data` / `*_buf_read_valid`. It is the responder end of the core's L2 read interface, and one instance serves the weight port or the activation port. It also contains a burst fill port that the DDR-side loader uses to preload rows before and during a layer.

## Interface
Parameters:
- `DATA_W`, default 64: row width; equals `WEI_BUF_DATA` or `ACT_BUF_DATA`.
- `ROWS`, default 1024: number of rows; need not be a power of two.
- `ADDR_W`, default 10: address width, ceil(log2(ROWS)); equals `L2_*_BUF_ROWS_LOG2`.

Ports (one clock; reset is asynchronous and active-low):
- `core_clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `buf_read_ready` in 1: core read request for this cycle.
- `buf_read_addr` in ADDR_W: row requested.
- `buf_read_valid` out 1: the row accepted last cycle is on `buf_read_data`.
- `buf_read_data` out DATA_W: returned row.
- `buf_read_err` out 1: sticky flag, set by any accepted address ≥ ROWS.
- `fill_start` in 1: one-cycle pulse that begins a burst.
- `fill_base` in ADDR_W: first row of the burst.
- `fill_len` in ADDR_W+1: beat count.
- `fill_valid` in 1: beat present.
- `fill_data` in DATA_W: beat payload.
- `fill_ready` out 1: high in FILL.
- `fill_done` out 1: one-cycle pulse after the last beat.
- `busy` out 1: state ≠ IDLE.

## Operation
- FSM states: IDLE, FILL, DONE.
- IDLE → FILL on `fill_start` with `fill_len` ≠ 0. Base and len are latched, `cnt` is cleared to 0. `fill_start` with len 0 is ignored.
- In FILL, every cycle where `fill_valid` && `fill_ready` writes `fill_data` to row (base+cnt) mod ROWS, then increments `cnt`.
  - When beat len−1 is written, the FSM moves to DONE.
- DONE lasts one cycle. `fill_done` = 1, then the FSM returns to IDLE.
- `fill_start` outside IDLE is ignored.
- Request acceptance: a request is accepted when `buf_read_ready` is high and the address is servable.
  - In IDLE and DONE every address is servable.
  - In FILL, servability depends on `L2_RD_BYPASS_EN`.
- Streaming: each cycle that `buf_read_ready` stays high is a new request. There is no per-request handshake beyond `buf_read_valid`.
- A request that is not accepted produces no `buf_read_valid`. The core keeps `buf_read_ready` and the address asserted and retries.
- Out-of-range address (≥ ROWS): the request is still accepted and returns data 0 with valid 1, and `buf_read_err` is set.
- Same-cycle read and write to the same row in IDLE/DONE cannot occur, because writes happen only in FILL.
- Memory contents are not reset.

## Timing
- Read latency is exactly 1 cycle: if the request is accepted at edge t, then `buf_read_valid` = 1 and `buf_read_data` = mem[addr(t)] after edge t+1.
- Throughput is one row per cycle.
- `buf_read_valid` drops one cycle after `buf_read_ready` drops.
- `buf_read_data` holds its last value while valid is low.
- A fill write is visible to a read accepted on the following edge.
- Reset values: `buf_read_valid` 0, `buf_read_data` 0, `buf_read_err` 0, `fill_ready` 0, `fill_done` 0, `busy` 0, state IDLE, `cnt` 0.
- Reset mid-burst:
  - The burst is abandoned and no `fill_done` is issued.
  - An in-flight read is dropped: valid is 0 after reset.
  - Rows already written keep their data.

## Configuration
- `L2_RD_BYPASS_EN` defined: during FILL an address is servable when either condition holds:
  - It was already written in this burst (offset (addr−base) mod ROWS < `cnt`).
  - It equals the row being written this cycle with `fill_valid` high. In this case `fill_data` is forwarded to `buf_read_data` on the next edge.
- `L2_RD_BYPASS_EN` undefined: no address is servable in FILL. Reads stall until DONE.

## Structure
- Shared package `l2_buf_pkg`: FSM state encoding (IDLE = 2'd0, FILL = 2'd1, DONE = 2'd2) and default widths (DATA_W, ROWS, ADDR_W).
- Sub-module `l2_sram_1r1w`: register array with a synchronous read port and a write port. It has no reset and can be swapped for a macro later.
- The top level contains the FSM, the fill counter, servability logic, the bypass mux, the out-of-range zeroing and the error flag.

## Test plan
- Preload of 4 rows with len 4 and base 0 (data A0..A3) → `fill_ready` is high for the 4 beats, `fill_done` pulses one cycle after beat 3, and `busy` falls after that.
- Stream reads of addr 0, 1, 2, 3 on consecutive cycles in IDLE → valid is high for 4 cycles, data is A0..A3, each 1 cycle after its request.
- Read of addr ROWS (1024) → valid 1, data 0, and `buf_read_err` stays 1 until reset.
- Burst with base 1022 and len 4 → writes land in rows 1022, 1023, 0, 1; reading row 0 afterwards returns beat 2.
- Read of row 5 while FILL is at `cnt` 2 (base 4):
  - With `L2_RD_BYPASS_EN`: row 5 returns after 1 cycle.
  - Without it: no valid until DONE, then the row returns 1 cycle later.
- `rst_n` low during beat 2 of a 6-beat burst → all outputs are 0, no `fill_done`, rows 0..1 keep their data, and a new `fill_start` is accepted.

Source files
------------

// File: rtl/l2_buf_pkg.sv
// Shared types and default widths for the L2 buffer read server.
package l2_buf_pkg;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_ROWS   = 1024;
    localparam int DEF_ADDR_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    // Source of the registered read response
    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_MEM  = 2'd1,
        SEL_FWD  = 2'd2
    } rd_sel_t;
endpackage

// File: rtl/l2_sram_1r1w.sv
// Row storage: one synchronous read port, one write port, no reset.
module l2_sram_1r1w #(
    parameter int DATA_W = 64,
    parameter int ROWS   = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [ROWS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/l2_buf_read_server.sv
// L2 buffer responder: 1-cycle row reads plus a burst fill port.
// Optional feature macro: L2_RD_BYPASS_EN (serve written/forwarded rows during FILL).
module l2_buf_read_server
    import l2_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ROWS   = DEF_ROWS,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              core_clk,
    input  logic              rst_n,
    input  logic              buf_read_ready,
    input  logic [ADDR_W-1:0] buf_read_addr,
    output logic              buf_read_valid,
    output logic [DATA_W-1:0] buf_read_data,
    output logic              buf_read_err,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [ADDR_W:0]   fill_len,
    input  logic              fill_valid,
    input  logic [DATA_W-1:0] fill_data,
    output logic              fill_ready,
    output logic              fill_done,
    output logic              busy
);
    localparam logic [ADDR_W:0]   ROWS_W   = (ADDR_W+1)'(ROWS);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] wptr, base_wrap;
    logic [ADDR_W:0]   len_q, cnt;
    logic              start_ok, wr_en, last_beat;
    logic              oor, fwd, servable, accept;
    rd_sel_t           rd_sel;
    logic [DATA_W-1:0] fwd_q, mem_rdata;

    assign start_ok  = fill_start && (fill_len != '0);
    assign wr_en     = (state == FILL) && fill_valid;
    assign last_beat = wr_en && ((cnt + CNT_ONE) == len_q);
    // fill_base may lie in [ROWS, 2^ADDR_W) when ROWS is not a power of two
    assign base_wrap = ({1'b0, fill_base} >= ROWS_W) ? fill_base - ADDR_W'(ROWS) : fill_base;

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_ok) state_nx = FILL;
            FILL:    if (last_beat) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign fill_ready = (state == FILL);
    assign fill_done  = (state == DONE);
    assign busy       = (state != IDLE);

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            len_q <= '0;
            cnt   <= '0;
        end else if (state == IDLE && start_ok) begin
            wptr  <= base_wrap;
            len_q <= fill_len;
            cnt   <= '0;
        end else if (wr_en) begin
            cnt  <= cnt + CNT_ONE;
            wptr <= (wptr == LAST_ROW) ? '0 : wptr + ADDR_W'(1);
        end
    end

    assign oor = ({1'b0, buf_read_addr} >= ROWS_W);

`ifdef L2_RD_BYPASS_EN
    logic [ADDR_W-1:0] base_q, off;

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n)                          base_q <= '0;
        else if (state == IDLE && start_ok) base_q <= base_wrap;
    end

    // Offset of the requested row from the burst base, modulo ROWS
    assign off = (buf_read_addr >= base_q) ? buf_read_addr - base_q
                                           : buf_read_addr + ADDR_W'(ROWS) - base_q;
    assign fwd      = wr_en && (buf_read_addr == wptr);
    assign servable = (state != FILL) || fwd || (!oor && ({1'b0, off} < cnt));
`else
    assign fwd      = 1'b0;
    assign servable = (state != FILL);
`endif

    assign accept = buf_read_ready && servable;

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_read_valid <= 1'b0;
            buf_read_err   <= 1'b0;
            rd_sel         <= SEL_ZERO;
            fwd_q          <= '0;
        end else begin
            buf_read_valid <= accept;
            if (accept) begin
                rd_sel <= fwd ? SEL_FWD : (oor ? SEL_ZERO : SEL_MEM);
                if (oor) buf_read_err <= 1'b1;
            end
            if (accept && fwd) fwd_q <= fill_data;
        end
    end

    l2_sram_1r1w #(.DATA_W(DATA_W), .ROWS(ROWS), .ADDR_W(ADDR_W)) u_sram (
        .clk   (core_clk),
        .we    (wr_en),
        .waddr (wptr),
        .wdata (fill_data),
        .re    (accept && !oor && !fwd),
        .raddr (buf_read_addr),
        .rdata (mem_rdata)
    );

    // Select is only updated on accept, so data holds while valid is low
    always_comb begin
        buf_read_data = '0;
        case (rd_sel)
            SEL_MEM: buf_read_data = mem_rdata;
            SEL_FWD: buf_read_data = fwd_q;
            default: buf_read_data = '0;
        endcase
    end
endmodule

// File: tb/tb_l2_buf_read_server.sv
// Randomized directed bench for l2_buf_read_server against a row-array model.
module tb_l2_buf_read_server;
    localparam int DW   = 64;
    localparam int ROWS = 1000;
    localparam int AW   = 10;

    logic          core_clk = 1'b0;
    logic          rst_n;
    logic          buf_read_ready;
    logic [AW-1:0] buf_read_addr;
    logic          buf_read_valid;
    logic [DW-1:0] buf_read_data;
    logic          buf_read_err;
    logic          fill_start;
    logic [AW-1:0] fill_base;
    logic [AW:0]   fill_len;
    logic          fill_valid;
    logic [DW-1:0] fill_data;
    logic          fill_ready;
    logic          fill_done;
    logic          busy;

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] mem_m [ROWS];
    logic [DW-1:0] beats [$];
    int            rq [$];
    logic [DW-1:0] b [6];

    always #5 core_clk = ~core_clk;

    l2_buf_read_server #(.DATA_W(DW), .ROWS(ROWS), .ADDR_W(AW)) dut (
        .core_clk(core_clk), .rst_n(rst_n),
        .buf_read_ready(buf_read_ready), .buf_read_addr(buf_read_addr),
        .buf_read_valid(buf_read_valid), .buf_read_data(buf_read_data),
        .buf_read_err(buf_read_err), .fill_start(fill_start),
        .fill_base(fill_base), .fill_len(fill_len), .fill_valid(fill_valid),
        .fill_data(fill_data), .fill_ready(fill_ready), .fill_done(fill_done),
        .busy(busy)
    );

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [DW-1:0] expv(input int a);
        return (a >= ROWS) ? '0 : mem_m[a];
    endfunction

    task automatic start_burst(input int base, input int len);
        fill_start = 1'b1;
        fill_base  = AW'(base);
        fill_len   = (AW+1)'(len);
        tick();
        fill_start = 1'b0;
    endtask

    // Full burst with random gaps between beats; model tracks row contents.
    task automatic do_fill(input int base, input int len);
        int n = 0;
        beats.delete();
        start_burst(base, len);
        chk("fill_ready_on", fill_ready, 1);
        chk("busy_fill", busy, 1);
        while (n < len) begin
            logic v;
            v = ($urandom_range(3) != 0);
            fill_valid = v;
            fill_data  = rnd64();
            tick();
            if (v) begin
                mem_m[(base + n) % ROWS] = fill_data;
                beats.push_back(fill_data);
                n++;
            end
        end
        fill_valid = 1'b0;
        chk("fill_done_pulse", fill_done, 1);
        chk("fill_ready_off", fill_ready, 0);
        tick();
        chk("fill_done_clear", fill_done, 0);
        chk("busy_idle", busy, 0);
    endtask

    // Stream the addresses in rq back to back, then drop ready.
    task automatic read_seq();
        int last = 0;
        foreach (rq[i]) begin
            buf_read_ready = 1'b1;
            buf_read_addr  = AW'(rq[i]);
            tick();
            chk("rd_valid", buf_read_valid, 1);
            chk("rd_data", buf_read_data, expv(rq[i]));
            last = rq[i];
        end
        buf_read_ready = 1'b0;
        tick();
        chk("rd_valid_drop", buf_read_valid, 0);
        chk("rd_data_hold", buf_read_data, expv(last));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        buf_read_ready = 1'b0; buf_read_addr = '0;
        fill_start = 1'b0; fill_base = '0; fill_len = '0;
        fill_valid = 1'b0; fill_data = '0;
        #3;
        chk("rst_valid", buf_read_valid, 0);
        chk("rst_data", buf_read_data, 0);
        chk("rst_err", buf_read_err, 0);
        chk("rst_fill_ready", fill_ready, 0);
        chk("rst_fill_done", fill_done, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(posedge core_clk);
        #1 rst_n = 1'b1;
        tick();

        // len 0 start is ignored
        start_burst(7, 0);
        chk("len0_ignored", busy, 0);

        // preload rows 0..3 and stream them back
        do_fill(0, 4);
        rq.delete();
        for (int i = 0; i < 4; i++) rq.push_back(i);
        read_seq();
        chk("err_clean", buf_read_err, 0);

        // out-of-range reads return zero and set the sticky error
        rq.delete();
        rq.push_back(ROWS); rq.push_back(1023); rq.push_back(2);
        read_seq();
        chk("err_set", buf_read_err, 1);

        // wrapping burst: rows ROWS-2, ROWS-1, 0, 1
        do_fill(ROWS - 2, 4);
        rq.delete();
        rq.push_back(ROWS - 2); rq.push_back(ROWS - 1); rq.push_back(1); rq.push_back(0);
        read_seq();
        chk("wrap_row0_beat2", buf_read_data, beats[2]);
        chk("err_sticky", buf_read_err, 1);

        // read during FILL: base 4, request row 5 at cnt 2
        foreach (b[k]) b[k] = rnd64();
        start_burst(4, 6);
        fill_valid = 1'b1;
        fill_data = b[0]; tick(); mem_m[4] = b[0];
        fill_data = b[1]; tick(); mem_m[5] = b[1];
        fill_valid = 1'b0;
        buf_read_ready = 1'b1;
        buf_read_addr = AW'(5);
        tick();
`ifdef L2_RD_BYPASS_EN
        chk("byp_written_valid", buf_read_valid, 1);
        chk("byp_written_data", buf_read_data, b[1]);
        buf_read_addr = AW'(8);
        tick();
        chk("byp_unwritten_stall", buf_read_valid, 0);
        buf_read_addr = AW'(6);
        fill_valid = 1'b1;
        fill_data = b[2];
        tick();
        mem_m[6] = b[2];
        chk("byp_fwd_valid", buf_read_valid, 1);
        chk("byp_fwd_data", buf_read_data, b[2]);
        buf_read_ready = 1'b0;
        for (int k = 3; k < 6; k++) begin
            fill_data = b[k]; tick(); mem_m[4 + k] = b[k];
        end
        fill_valid = 1'b0;
        chk("byp_done", fill_done, 1);
        tick();
        chk("byp_done_clear", fill_done, 0);
`else
        chk("stall_valid", buf_read_valid, 0);
        fill_valid = 1'b1;
        for (int k = 2; k < 6; k++) begin
            fill_data = b[k]; tick(); mem_m[4 + k] = b[k];
            chk("stall_in_fill", buf_read_valid, 0);
        end
        fill_valid = 1'b0;
        chk("stall_done", fill_done, 1);
        tick();
        chk("stall_release_valid", buf_read_valid, 1);
        chk("stall_release_data", buf_read_data, b[1]);
        chk("stall_done_clear", fill_done, 0);
        buf_read_ready = 1'b0;
        tick();
        chk("stall_valid_drop", buf_read_valid, 0);
`endif
        rq.delete();
        for (int i = 4; i < 10; i++) rq.push_back(i);
        read_seq();

        // reset during beat 2 of a 6-beat burst
        start_burst(0, 6);
        fill_valid = 1'b1;
        fill_data = rnd64(); tick(); mem_m[0] = fill_data;
        fill_data = rnd64(); tick(); mem_m[1] = fill_data;
        fill_data = rnd64();
        buf_read_ready = 1'b1;
        buf_read_addr = AW'(0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", buf_read_valid, 0);
        chk("mid_rst_data", buf_read_data, 0);
        chk("mid_rst_err", buf_read_err, 0);
        chk("mid_rst_fill_ready", fill_ready, 0);
        chk("mid_rst_fill_done", fill_done, 0);
        chk("mid_rst_busy", busy, 0);
        fill_valid = 1'b0;
        buf_read_ready = 1'b0;
        @(posedge core_clk);
        #1 rst_n = 1'b1;
        tick();
        chk("post_rst_no_done", fill_done, 0);
        chk("post_rst_valid", buf_read_valid, 0);
        rq.delete();
        rq.push_back(0); rq.push_back(1);
        read_seq();
        do_fill(10, 2);
        rq.delete();
        rq.push_back(10); rq.push_back(11);
        read_seq();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
